ntt_stage_controller: RTL and testbench

//  Sequencing FSM for the 512-point mixed-radix NTT. Walks the 4 stages (p) and 32 butterfly slots (j) per stage.

---
 rtl/ntt_stage_controller_pkg.sv | 32 +++
 rtl/ntt_stage_controller_dff.sv | 30 +++
 rtl/ntt_stage_controller.sv | 163 ++++++++++++++++
 tb/tb_ntt_stage_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_stage_controller_pkg.sv
// Shared constants, state encoding and k-mapping helper for ntt_stage_controller.
// Revision: 1.0
`default_nettype none

package ntt_stage_controller_pkg;

  localparam logic [1:0] P_FIRST_FWD = 2'd3;
  localparam logic [1:0] P_LAST_FWD  = 2'd0;
  localparam int         SLOTS_LOG2  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] k_shift(input logic [1:0] p);
    case (p)
      2'd3:    return 3'd4;
      2'd2:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] k_map(input logic [1:0] p, input logic [SLOTS_LOG2-1:0] j);
    return 5'(j >> k_shift(p));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_stage_controller_dff.sv
// Enabled D flip-flop bank with asynchronous active-low reset to a configurable value.
// Revision: 1.0
`default_nettype none

module ntt_stage_controller_dff #(
  parameter int                    DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/ntt_stage_controller.sv
// ntt_stage_controller: stage/slot sequencer emitting {conf,k,p} for the 512-point NTT.
// Optional INTT ordering with macro NTT_STAGE_CTRL_INTT_EN. Revision: 1.0
`default_nettype none

module ntt_stage_controller
  import ntt_stage_controller_pkg::*;
#(
  parameter int SLOTS     = 32,
  parameter int STAGE_GAP = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_intt,
  input  logic       i_stall,
  output logic [3:0] o_conf,
  output logic [4:0] o_k,
  output logic [1:0] o_p,
  output logic       o_v_out,
  output logic       o_busy,
  output logic       o_done
);

  localparam int                    GAP_W    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [SLOTS_LOG2-1:0] J_LAST   = SLOTS_LOG2'(SLOTS - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  state_t                  r_state;
  logic [SLOTS_LOG2-1:0]   r_j;
  logic [GAP_W-1:0]        r_gap;
  logic [1:0]              r_p;
  logic                    r_intt;
  logic                    r_v_out;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_intt_new;
  logic                    w_start_ok;
  logic                    w_emit;
  logic [1:0]              w_first_p;
  logic [1:0]              w_last_p;
  logic [1:0]              w_next_p;
  logic [1:0]              w_emit_p;
  logic [SLOTS_LOG2-1:0]   w_emit_j;
  logic                    w_emit_intt;
  logic [11:0]             w_triple_d;
  logic [11:0]             w_triple_q;
  logic                    w_pad_unused;

`ifdef NTT_STAGE_CTRL_INTT_EN
  assign w_intt_new = i_intt;
`else
  logic w_intt_unused;
  assign w_intt_unused = i_intt;
  assign w_intt_new    = 1'b0;
`endif

  // INTT walks the forward stage order backwards, so first/last simply swap.
  assign w_start_ok  = (r_state == S_IDLE) && i_start;
  assign w_emit      = w_start_ok || ((r_state == S_RUN) && !i_stall);
  assign w_first_p   = w_intt_new ? P_LAST_FWD : P_FIRST_FWD;
  assign w_last_p    = r_intt ? P_FIRST_FWD : P_LAST_FWD;
  assign w_next_p    = r_intt ? (r_p + 2'd1) : (r_p - 2'd1);
  assign w_emit_p    = w_start_ok ? w_first_p : r_p;
  assign w_emit_j    = w_start_ok ? '0 : r_j;
  assign w_emit_intt = w_start_ok ? w_intt_new : r_intt;

  assign w_triple_d = {1'b0,
                       1'b0,
                       w_emit_p == (w_emit_intt ? P_LAST_FWD : P_FIRST_FWD),
                       w_emit_p == (w_emit_intt ? P_FIRST_FWD : P_LAST_FWD),
                       w_emit_intt,
                       k_map(w_emit_p, w_emit_j),
                       w_emit_p};

  ntt_stage_controller_dff #(
    .DATA_WIDTH  (12),
    .RESET_VALUE ({1'b0, 4'h0, 5'd0, P_FIRST_FWD})
  ) u_triple_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_emit),
    .i_d   (w_triple_d),
    .o_q   (w_triple_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_gap   <= '0;
      r_p     <= P_FIRST_FWD;
      r_intt  <= 1'b0;
      r_v_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_v_out <= w_emit;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_p     <= w_first_p;
            r_j     <= SLOTS_LOG2'(1);
            r_gap   <= '0;
            r_intt  <= w_intt_new;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if (r_j == J_LAST) begin
              r_j <= '0;
              if (r_p == w_last_p) begin
                r_state <= S_DONE;
              end else begin
                r_p   <= w_next_p;
                r_gap <= '0;
                if (STAGE_GAP != 0) begin
                  r_state <= S_GAP;
                end
              end
            end else begin
              r_j <= r_j + SLOTS_LOG2'(1);
            end
          end
        end
        S_GAP: begin
          if (!i_stall) begin
            if (r_gap == GAP_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
        end
        S_DONE: begin
          // First DONE cycle raises done; the second returns to IDLE so a start
          // presented while done is visible is still ignored.
          if (!r_done) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pad_unused = w_triple_q[11];
  assign o_conf       = w_triple_q[10:7];
  assign o_k          = w_triple_q[6:2];
  assign o_p          = w_triple_q[1:0];
  assign o_v_out      = r_v_out;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ntt_stage_controller.sv
// Self-checking bench for ntt_stage_controller (STAGE_GAP=3 and STAGE_GAP=0 instances).
// Revision: 1.0
`default_nettype none

module tb_ntt_stage_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, intt = 1'b0, stall = 1'b0;
  logic       start0 = 1'b0, intt0 = 1'b0, stall0 = 1'b0;
  logic [3:0] o_conf, o_conf0;
  logic [4:0] o_k, o_k0;
  logic [1:0] o_p, o_p0;
  logic       o_v_out, o_busy, o_done;
  logic       o_v_out0, o_busy0, o_done0;

  ntt_stage_controller #(.SLOTS(32), .STAGE_GAP(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_intt(intt), .i_stall(stall),
    .o_conf(o_conf), .o_k(o_k), .o_p(o_p), .o_v_out(o_v_out), .o_busy(o_busy), .o_done(o_done)
  );

  ntt_stage_controller #(.SLOTS(32), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_intt(intt0), .i_stall(stall0),
    .o_conf(o_conf0), .o_k(o_k0), .o_p(o_p0), .o_v_out(o_v_out0), .o_busy(o_busy0), .o_done(o_done0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] q[$];
  logic [10:0] q0[$];
  bit          done_seen = 0, done0_seen = 0;
  int          done_cyc = 0, done0_cyc = 0, start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {conf,k,p} for every slot of a full transform.
  task automatic push_exp(input bit sel, input bit inv);
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 32; j++) begin
        int          p;
        int          k;
        logic [10:0] e;
        p = inv ? s : 3 - s;
        k = (p == 3) ? j / 16 : (p == 2) ? j / 4 : j;
        e = {1'b0, 1'(s == 0), 1'(s == 3), inv, 5'(k), 2'(p)};
        if (sel) q0.push_back(e);
        else     q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (o_v_out) begin
      if (q.size() == 0) chk("extra_valid", q.size(), 1);
      else               chk("triple", {o_conf, o_k, o_p}, q.pop_front());
    end
    if (o_done) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  always @(negedge clk) begin
    if (o_v_out0) begin
      if (q0.size() == 0) chk("extra_valid_gap0", q0.size(), 1);
      else                chk("triple_gap0", {o_conf0, o_k0, o_p0}, q0.pop_front());
    end
    if (o_done0) begin
      done0_seen = 1;
      done0_cyc  = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit sel, input bit iv);
    if (sel) start0 = 1'b1;
    else begin
      start = 1'b1;
      intt  = iv;
    end
    tick();
    start     = 1'b0;
    start0    = 1'b0;
    intt      = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input bit sel, input int exp_len, input string tag);
    int n = 0;
    while (!(sel ? done0_seen : done_seen) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, sel ? done0_seen : done_seen, 1);
    if (sel ? done0_seen : done_seen) begin
      chk({tag, "_length"}, (sel ? done0_cyc : done_cyc) - start_cyc, exp_len);
    end
    chk({tag, "_leftover"}, sel ? q0.size() : q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_width"}, sel ? o_done0 : o_done, 0);
    done_seen  = 0;
    done0_seen = 0;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    @(negedge clk);
    chk("reset_state", {o_conf, o_k, o_p, o_v_out, o_busy, o_done}, {4'h0, 5'h0, 2'h3, 3'b000});
    tick();
    rst_n = 1'b1;
    tick();

    // Forward run with an extra start (and intt=1) while busy
    push_exp(0, 0);
    go(0, 0);
    @(negedge clk);
    chk("first_valid", o_v_out, 1);
    chk("busy_after_start", o_busy, 1);
    tick();
    repeat (18) tick();
    start = 1'b1;
    intt  = 1'b1;
    tick();
    start = 1'b0;
    intt  = 1'b0;
    wait_done(0, 137, "fwd");

    // Stall 5 cycles where p=2 j=10 would appear
    push_exp(0, 0);
    go(0, 0);
    repeat (44) tick();
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_v_out", o_v_out, 0);
    repeat (2) tick();
    stall = 1'b0;
    wait_done(0, 142, "stall");

    // No inter-stage gap
    push_exp(1, 0);
    go(1, 0);
    wait_done(1, 128, "gap0");

    // Reset mid-transform at p=1 k=17
    push_exp(0, 0);
    go(0, 0);
    repeat (87) tick();
    chk("pre_reset_pk", {o_p, o_k}, {2'd1, 5'd17});
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", {o_conf, o_k, o_p, o_v_out, o_busy, o_done}, {4'h0, 5'h0, 2'h3, 3'b000});
    tick();
    rst_n = 1'b1;
    q.delete();
    repeat (3) tick();
    chk("no_done_after_abort", done_seen, 0);
    push_exp(0, 0);
    go(0, 0);
    wait_done(0, 137, "post_reset");

    // Start with intt=1
`ifdef NTT_STAGE_CTRL_INTT_EN
    push_exp(0, 1);
`else
    push_exp(0, 0);
`endif
    go(0, 1);
    wait_done(0, 137, "intt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
